// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, fetches one word at a time over req/ack,
// hands it to decode over valid/ready and steers the next PC from the retiring op.
module fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rstn,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic [31:0] inst_out,
   output logic [31:0] pc_out,
   output logic [31:0] pc_plus4,
   output logic        inst_valid,
   input  logic        inst_ready,
   input  logic [4:0]  npc_op,
   input  logic        br_taken,
   input  logic [31:0] imm,
   input  logic [31:0] alu_out,
   output logic        fetch_fault
);

   localparam logic [31:0] NOP_INST = 32'h0000_0013;

   localparam logic [4:0] NPC_PLUS4  = 5'b00000;
   localparam logic [4:0] NPC_BRANCH = 5'b00001;
   localparam logic [4:0] NPC_JAL    = 5'b00010;
   localparam logic [4:0] NPC_JALR   = 5'b00100;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_FETCH = 2'd1,
      S_HOLD  = 2'd2,
      S_FAULT = 2'd3
   } state_t;

   state_t      r_state;
   logic [31:0] r_pc;
   logic [31:0] r_inst;
   logic        r_req;
   logic        r_valid;
   logic        r_fault;

   logic [31:0] w_pc_plus4;
   logic [31:0] w_npc;
   logic        w_misaligned;

   assign w_pc_plus4 = r_pc + 32'd4;

   // Unknown or multi-hot encodings fall back to sequential flow.
   always_comb begin
      w_npc = w_pc_plus4;
      case (npc_op)
         NPC_PLUS4:  w_npc = w_pc_plus4;
         NPC_BRANCH: w_npc = br_taken ? (r_pc + imm) : w_pc_plus4;
         NPC_JAL:    w_npc = r_pc + imm;
         NPC_JALR:   w_npc = alu_out & ~32'h0000_0001;
         default:    w_npc = w_pc_plus4;
      endcase
   end

   assign w_misaligned = (w_npc[1:0] != 2'b00);

   always_ff @(posedge clk) begin
      if (!rstn) begin
         r_state <= S_IDLE;
         r_pc    <= RESET_PC;
         r_inst  <= NOP_INST;
         r_req   <= 1'b0;
         r_valid <= 1'b0;
         r_fault <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               r_state <= S_FETCH;
               r_req   <= 1'b1;
            end
            S_FETCH: begin
               if (imem_ack) begin
                  r_inst  <= imem_rdata;
                  r_state <= S_HOLD;
                  r_req   <= 1'b0;
                  r_valid <= 1'b1;
               end
            end
            S_HOLD: begin
               if (inst_ready) begin
                  // Faulting target is still loaded so it can be inspected.
                  r_pc    <= w_npc;
                  r_valid <= 1'b0;
                  if (w_misaligned) begin
                     r_state <= S_FAULT;
                     r_fault <= 1'b1;
                  end else begin
                     r_state <= S_FETCH;
                     r_req   <= 1'b1;
                  end
               end
            end
            S_FAULT: begin
               r_state <= S_FAULT;
            end
            default: begin
               r_state <= S_IDLE;
               r_req   <= 1'b0;
               r_valid <= 1'b0;
            end
         endcase
      end
   end

   assign imem_req    = r_req;
   assign imem_addr   = r_pc;
   assign inst_out    = r_inst;
   assign pc_out      = r_pc;
   assign pc_plus4    = w_pc_plus4;
   assign inst_valid  = r_valid;
   assign fetch_fault = r_fault;

endmodule
